// File: rtl/br_stack_pkg.sv
// Shared widths, branch-resolution encodings and the map-table entry/snapshot types for the branch stack.
// Also provides the CDB ready-forwarding helper used by both the checkpoint storage and the recovery read path.
package br_stack_pkg;

   localparam int MT_NUM     = 32;
   localparam int PRF_IDX_W  = 6;
   localparam int FL_PTR_W   = 5;
   localparam int BR_STATE_W = 2;

   localparam logic [BR_STATE_W-1:0] BR_NONE       = 2'd0;
   localparam logic [BR_STATE_W-1:0] BR_PR_CORRECT = 2'd1;
   localparam logic [BR_STATE_W-1:0] BR_PR_WRONG   = 2'd2;

   typedef struct packed {
      logic                 rdy;
      logic [PRF_IDX_W-1:0] preg;
   } mt_entry_t;

   typedef mt_entry_t [MT_NUM-1:0] mt_snap_t;

   // Mark every entry mapped to the broadcast tag as ready.
   function automatic mt_snap_t cdb_fwd(input mt_snap_t s, input logic en, input logic [PRF_IDX_W-1:0] preg);
      mt_snap_t r;
      r = s;
      for (int i = 0; i < MT_NUM; i++) begin
         if (en && (s[i].preg == preg)) r[i].rdy = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/br_stack_ckpt.sv
// One checkpoint slot: map-table snapshot plus free-list head, kept ready-current from the CDB.
// Write/update lands at the edge; read port is combinational with the current CDB broadcast forwarded.
module br_ckpt
   import br_stack_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en_i,
   input  logic                 active_i,
   input  mt_snap_t             wr_snap_i,
   input  logic [FL_PTR_W-1:0]  wr_fl_head_i,
   input  logic                 cdb_en_i,
   input  logic [PRF_IDX_W-1:0] cdb_preg_i,
   output mt_snap_t             rd_snap_o,
   output logic [FL_PTR_W-1:0]  fl_head_o
);

   mt_snap_t            snap_q, snap_d;
   logic [FL_PTR_W-1:0] fl_head_q, fl_head_d;

   always_comb begin
      snap_d    = snap_q;
      fl_head_d = fl_head_q;
      if (wr_en_i) begin
         snap_d    = cdb_fwd(wr_snap_i, cdb_en_i, cdb_preg_i);
         fl_head_d = wr_fl_head_i;
      end else if (active_i) begin
         snap_d    = cdb_fwd(snap_q, cdb_en_i, cdb_preg_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q    <= '0;
         fl_head_q <= '0;
      end else begin
         snap_q    <= snap_d;
         fl_head_q <= fl_head_d;
      end
   end

   assign rd_snap_o = cdb_fwd(snap_q, cdb_en_i, cdb_preg_i);
   assign fl_head_o = fl_head_q;

endmodule

// File: rtl/br_stack.sv
// Branch checkpoint stack: grants the lowest free slot and returns a checkpoint on mispredict, both in 0 cycles.
// A push while full (registered) or during a mispredict is dropped with br_tag_o=0; dispatch must stall on full_o.
module br_stack
   import br_stack_pkg::*;
#(
   parameter int BR_NUM = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_en_i,
   input  mt_snap_t              bak_data_i,
   input  logic [FL_PTR_W-1:0]   fl_head_i,
   input  logic                  cdb_en_i,
   input  logic [PRF_IDX_W-1:0]  cdb_preg_i,
   input  logic [BR_STATE_W-1:0] branch_state_i,
   input  logic [BR_NUM-1:0]     br_tag_i,
   output logic [BR_NUM-1:0]     br_tag_o,
   output logic [BR_NUM-1:0]     br_mask_o,
   output logic                  full_o,
   output mt_snap_t              rc_mt_all_data_o,
   output logic [FL_PTR_W-1:0]   rc_fl_head_o
);

   logic [BR_NUM-1:0] valid_q, valid_d;
   logic [BR_NUM-1:0] dep_mask_q [BR_NUM];
   logic [BR_NUM-1:0] dep_mask_d [BR_NUM];

   logic              tag_onehot, tag_hit, res_ok, correct, wrong, push_ok;
   logic [BR_NUM-1:0] grant, clr_bit, squash;

   mt_snap_t            rd_snap    [BR_NUM];
   logic [FL_PTR_W-1:0] rd_fl_head [BR_NUM];

   assign br_mask_o = valid_q;
   assign full_o    = &valid_q;

   always_comb begin
      tag_onehot = (br_tag_i != '0) && ((br_tag_i & (br_tag_i - BR_NUM'(1))) == '0);
      tag_hit    = |(br_tag_i & valid_q);
      res_ok     = tag_onehot && tag_hit;
      correct    = res_ok && (branch_state_i == BR_PR_CORRECT);
      wrong      = res_ok && (branch_state_i == BR_PR_WRONG);
      // Gated by rst_n so the grant reads 0 while reset is held.
      push_ok    = rst_n && push_en_i && !full_o && (branch_state_i != BR_PR_WRONG);
   end

   always_comb begin
      grant = '0;
      for (int j = 0; j < BR_NUM; j++) begin
         if (!valid_q[j] && (grant == '0)) grant[j] = 1'b1;
      end
      br_tag_o = push_ok ? grant : '0;
   end

   always_comb begin
      clr_bit = (correct || wrong) ? br_tag_i : '0;
      squash  = clr_bit;
      if (wrong) begin
         // Anything allocated while the mispredicted branch was outstanding is younger.
         for (int j = 0; j < BR_NUM; j++) begin
            if (valid_q[j] && |(dep_mask_q[j] & br_tag_i)) squash[j] = 1'b1;
         end
      end
      valid_d = (valid_q & ~squash) | br_tag_o;
      for (int j = 0; j < BR_NUM; j++) begin
         dep_mask_d[j] = dep_mask_q[j] & ~clr_bit;
         if (br_tag_o[j]) dep_mask_d[j] = valid_q & ~clr_bit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int j = 0; j < BR_NUM; j++) dep_mask_q[j] <= '0;
      end else begin
         valid_q <= valid_d;
         for (int j = 0; j < BR_NUM; j++) dep_mask_q[j] <= dep_mask_d[j];
      end
   end

   for (genvar g = 0; g < BR_NUM; g++) begin : g_ckpt
      br_ckpt u_ckpt (
         .clk          (clk),
         .rst_n        (rst_n),
         .wr_en_i      (br_tag_o[g]),
         .active_i     (valid_q[g]),
         .wr_snap_i    (bak_data_i),
         .wr_fl_head_i (fl_head_i),
         .cdb_en_i     (cdb_en_i),
         .cdb_preg_i   (cdb_preg_i),
         .rd_snap_o    (rd_snap[g]),
         .fl_head_o    (rd_fl_head[g])
      );
   end

   always_comb begin
      rc_mt_all_data_o = '0;
      rc_fl_head_o     = '0;
      if (wrong) begin
         for (int j = 0; j < BR_NUM; j++) begin
            if (br_tag_i[j]) begin
               rc_mt_all_data_o = rd_snap[j];
               rc_fl_head_o     = rd_fl_head[j];
            end
         end
         // The zero register is always ready.
         rc_mt_all_data_o[MT_NUM-1].rdy = 1'b1;
      end
   end

   a_resolve_legal : assert property (@(posedge clk) disable iff (!rst_n)
      ((branch_state_i == BR_PR_CORRECT) || (branch_state_i == BR_PR_WRONG)) |-> (tag_onehot && tag_hit));

endmodule

// File: tb/tb_br_stack.sv
module tb_br_stack;
   import br_stack_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  push_en_i;
   mt_snap_t              bak_data_i;
   logic [FL_PTR_W-1:0]   fl_head_i;
   logic                  cdb_en_i;
   logic [PRF_IDX_W-1:0]  cdb_preg_i;
   logic [BR_STATE_W-1:0] branch_state_i;
   logic [3:0]            br_tag_i;
   logic [3:0]            br_tag_o;
   logic [3:0]            br_mask_o;
   logic                  full_o;
   mt_snap_t              rc_mt_all_data_o;
   logic [FL_PTR_W-1:0]   rc_fl_head_o;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   br_stack #(.BR_NUM(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .push_en_i        (push_en_i),
      .bak_data_i       (bak_data_i),
      .fl_head_i        (fl_head_i),
      .cdb_en_i         (cdb_en_i),
      .cdb_preg_i       (cdb_preg_i),
      .branch_state_i   (branch_state_i),
      .br_tag_i         (br_tag_i),
      .br_tag_o         (br_tag_o),
      .br_mask_o        (br_mask_o),
      .full_o           (full_o),
      .rc_mt_all_data_o (rc_mt_all_data_o),
      .rc_fl_head_o     (rc_fl_head_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic mt_snap_t pat(input int base);
      mt_snap_t s;
      for (int i = 0; i < MT_NUM; i++) begin
         s[i].rdy  = 1'b0;
         s[i].preg = PRF_IDX_W'((base + i) % 64);
      end
      return s;
   endfunction

   task automatic idle();
      push_en_i      = 1'b0;
      bak_data_i     = '0;
      fl_head_i      = '0;
      cdb_en_i       = 1'b0;
      cdb_preg_i     = '0;
      branch_state_i = BR_NONE;
      br_tag_i       = '0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      idle();
   endtask

   // Push one checkpoint and check the same-cycle grant.
   task automatic push(input string tag, input mt_snap_t s, input logic [FL_PTR_W-1:0] fl, input logic [3:0] exp_tag);
      push_en_i  = 1'b1;
      bak_data_i = s;
      fl_head_i  = fl;
      #1;
      chk(tag, 64'(br_tag_o), 64'(exp_tag));
      next();
   endtask

   task automatic resolve(input logic [BR_STATE_W-1:0] st, input logic [3:0] tag);
      branch_state_i = st;
      br_tag_i       = tag;
   endtask

   initial begin
      mt_snap_t s;
      idle();
      rst_n = 1'b0;
      #3;
      chk("rst_tag",  64'(br_tag_o), 64'd0);
      chk("rst_mask", 64'(br_mask_o), 64'd0);
      chk("rst_full", 64'(full_o), 64'd0);
      chk("rst_rcfl", 64'(rc_fl_head_o), 64'd0);
      chk("rst_rcmt", 64'(|rc_mt_all_data_o), 64'd0);
      #20;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: fill, overflow, flush all via the oldest
      for (int k = 0; k < 4; k++) push("t1_grant", pat(k * 8), FL_PTR_W'(k + 3), 4'b0001 << k);
      chk("t1_full", 64'(full_o), 64'd1);
      chk("t1_mask", 64'(br_mask_o), 64'hf);
      push("t1_grant_full", pat(60), 5'd20, 4'b0000);
      chk("t1_mask_keep", 64'(br_mask_o), 64'hf);
      resolve(BR_PR_WRONG, 4'b0001);
      #1;
      chk("t1_rcfl", 64'(rc_fl_head_o), 64'd3);
      chk("t1_rc31", 64'(rc_mt_all_data_o[31]), 64'h5f);
      chk("t1_rc7",  64'(rc_mt_all_data_o[7]), 64'h07);
      next();
      chk("t1_mask_after", 64'(br_mask_o), 64'd0);
      chk("t1_full_after", 64'(full_o), 64'd0);

      // 2: CDB wakes a stored entry, then recovery sees RDY=1
      s = pat(0);
      s[3].preg = 6'd40;
      push("t2_grant", s, 5'd7, 4'b0001);
      cdb_en_i = 1'b1;
      cdb_preg_i = 6'd40;
      next();
      resolve(BR_PR_WRONG, 4'b0001);
      #1;
      chk("t2_rc3", 64'(rc_mt_all_data_o[3]), 64'h68);
      chk("t2_rc4", 64'(rc_mt_all_data_o[4]), 64'h04);
      chk("t2_rcfl", 64'(rc_fl_head_o), 64'd7);
      next();
      chk("t2_mask", 64'(br_mask_o), 64'd0);
      chk("t2_rc_idle", 64'(|rc_mt_all_data_o), 64'd0);

      // 3: mispredict the middle branch frees it and the younger one
      push("t3_a", pat(1), 5'd1, 4'b0001);
      push("t3_b", pat(2), 5'd2, 4'b0010);
      push("t3_c", pat(3), 5'd3, 4'b0100);
      resolve(BR_PR_WRONG, 4'b0010);
      #1;
      chk("t3_rcfl", 64'(rc_fl_head_o), 64'd2);
      chk("t3_rc0", 64'(rc_mt_all_data_o[0]), 64'h02);
      next();
      chk("t3_mask", 64'(br_mask_o), 64'b0001);
      push("t3_repush", pat(4), 5'd4, 4'b0010);
      chk("t3_mask2", 64'(br_mask_o), 64'b0011);
      resolve(BR_PR_WRONG, 4'b0001);
      next();
      chk("t3_mask3", 64'(br_mask_o), 64'd0);

      // 4: correct the older, then mispredict the younger alone
      push("t4_a", pat(5), 5'd9, 4'b0001);
      push("t4_b", pat(6), 5'd12, 4'b0010);
      resolve(BR_PR_CORRECT, 4'b0001);
      #1;
      chk("t4_rc_corr", 64'(rc_fl_head_o), 64'd0);
      next();
      chk("t4_mask", 64'(br_mask_o), 64'b0010);
      push("t4_c", pat(7), 5'd15, 4'b0001);
      chk("t4_mask2", 64'(br_mask_o), 64'b0011);
      // The new slot 0 is younger than B, so it goes too.
      resolve(BR_PR_WRONG, 4'b0010);
      #1;
      chk("t4_rcfl", 64'(rc_fl_head_o), 64'd12);
      next();
      chk("t4_mask3", 64'(br_mask_o), 64'd0);

      // 5: mispredict + push + forwarded CDB in one cycle
      s = pat(10);
      s[5].preg = 6'd50;
      push("t5_a", s, 5'd5, 4'b0001);
      resolve(BR_PR_WRONG, 4'b0001);
      push_en_i  = 1'b1;
      bak_data_i = pat(30);
      cdb_en_i   = 1'b1;
      cdb_preg_i = 6'd50;
      #1;
      chk("t5_grant", 64'(br_tag_o), 64'd0);
      chk("t5_rc5", 64'(rc_mt_all_data_o[5]), 64'h72);
      chk("t5_rc6", 64'(rc_mt_all_data_o[6]), 64'h10);
      next();
      chk("t5_mask", 64'(br_mask_o), 64'd0);

      // 6: correct-while-full does not free a slot for the same-cycle push
      for (int k = 0; k < 4; k++) push("t6_fill", pat(k), FL_PTR_W'(k), 4'b0001 << k);
      resolve(BR_PR_CORRECT, 4'b0100);
      push_en_i = 1'b1;
      bak_data_i = pat(40);
      #1;
      chk("t6_grant_rej", 64'(br_tag_o), 64'd0);
      next();
      chk("t6_mask", 64'(br_mask_o), 64'b1011);
      chk("t6_full", 64'(full_o), 64'd0);
      push("t6_grant", pat(41), 5'd6, 4'b0100);
      chk("t6_mask2", 64'(br_mask_o), 64'hf);
      resolve(BR_PR_WRONG, 4'b0001);
      push_en_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_tag", 64'(br_tag_o), 64'd0);
      chk("t6_rst_mask", 64'(br_mask_o), 64'd0);
      chk("t6_rst_full", 64'(full_o), 64'd0);
      chk("t6_rst_rcfl", 64'(rc_fl_head_o), 64'd0);
      chk("t6_rst_rcmt", 64'(|rc_mt_all_data_o), 64'd0);
      idle();
      #20;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
